vga_frame_mem_arbiter: RTL

- Shares one single-port synchronous pixel memory between two users: the VGA display scan-out and a pixel writer (CPU or pattern generator).
- Display reads have fixed priority during the active region, and the writer gets all blanking cycles.
- Driven by the column/row counters of the sync counter, so its pixel stream is aligned to the HSync/VSync generator.

---
 rtl/vga_frame_mem_arbiter_if.sv | 29 ++
 rtl/vga_frame_mem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_mem_arbiter_if.sv
// Bus bundle between the frame-memory arbiter, its sync counter, pixel writer and pixel memory.
interface vga_frame_mem_arbiter_if #(
  parameter int g_Addr_Width = 19,
  parameter int g_Data_Width = 12
);
  logic [9:0]              i_Col_Counter;
  logic [9:0]              i_Row_Counter;
  logic                    i_Wr_Req;
  logic [g_Addr_Width-1:0] i_Wr_Addr;
  logic [g_Data_Width-1:0] i_Wr_Data;
  logic                    o_Wr_Ack;
  logic                    o_Wr_Err;
  logic [g_Addr_Width-1:0] o_Mem_Addr;
  logic                    o_Mem_WE;
  logic [g_Data_Width-1:0] o_Mem_WData;
  logic [g_Data_Width-1:0] i_Mem_RData;
  logic [g_Data_Width-1:0] o_Pixel;
  logic                    o_Pixel_Valid;

  modport slave (
    input  i_Col_Counter, i_Row_Counter, i_Wr_Req, i_Wr_Addr, i_Wr_Data, i_Mem_RData,
    output o_Wr_Ack, o_Wr_Err, o_Mem_Addr, o_Mem_WE, o_Mem_WData, o_Pixel, o_Pixel_Valid
  );

  modport master (
    output i_Col_Counter, i_Row_Counter, i_Wr_Req, i_Wr_Addr, i_Wr_Data, i_Mem_RData,
    input  o_Wr_Ack, o_Wr_Err, o_Mem_Addr, o_Mem_WE, o_Mem_WData, o_Pixel, o_Pixel_Valid
  );
endinterface

// File: rtl/vga_frame_mem_arbiter.sv
// Shares one single-port pixel memory between VGA scan-out (priority in active area) and a writer.
// Build option: define VGA_WR_BUFFER_EN to put a 4-entry write FIFO in front of the writer FSM.
module vga_frame_mem_arbiter #(
  parameter int g_Total_Col  = 800,
  parameter int g_Active_Col = 640,
  parameter int g_Total_Row  = 525,
  parameter int g_Active_Row = 480,
  parameter int g_Addr_Width = 19,
  parameter int g_Data_Width = 12
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  vga_frame_mem_arbiter_if.slave bus
);

  typedef enum logic {W_IDLE = 1'b0, W_ACK = 1'b1} wr_state_t;

  localparam logic [9:0]              c_Act_Col    = 10'(g_Active_Col);
  localparam logic [9:0]              c_Act_Row    = 10'(g_Active_Row);
  localparam logic [9:0]              c_Last_Col   = 10'(g_Total_Col - 1);
  localparam logic [9:0]              c_Last_Row   = 10'(g_Total_Row - 1);
  localparam logic [g_Addr_Width-1:0] c_Line_Step  = g_Addr_Width'(g_Active_Col);
  localparam logic [g_Addr_Width:0]   c_Num_Pixels = (g_Addr_Width+1)'(g_Active_Col * g_Active_Row);

  wr_state_t               state_q, state_d;
  logic                    slot_s, wr_oor_s;
  logic [g_Addr_Width-1:0] line_base_q, line_base_d, rd_addr_s;
  logic [g_Addr_Width-1:0] mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d;
  logic [g_Data_Width-1:0] mem_wdata_q, mem_wdata_d;
  logic                    ack_q, ack_d, err_q, err_d;
  logic                    valid1_q, valid2_q, pix_valid_q;
  logic [g_Data_Width-1:0] rdata_q, pixel_q, pixel_d;

  assign slot_s    = (bus.i_Col_Counter < c_Act_Col) && (bus.i_Row_Counter < c_Act_Row);
  assign wr_oor_s  = ({1'b0, bus.i_Wr_Addr} >= c_Num_Pixels);
  assign rd_addr_s = line_base_q + {{(g_Addr_Width-10){1'b0}}, bus.i_Col_Counter};

  // Line base steps by one visible line at the end of each active line, so no multiplier is needed.
  always_comb begin
    line_base_d = line_base_q;
    if (bus.i_Col_Counter == c_Last_Col) begin
      if (bus.i_Row_Counter == c_Last_Row) begin
        line_base_d = '0;
      end else if (bus.i_Row_Counter < c_Act_Row) begin
        line_base_d = line_base_q + c_Line_Step;
      end else begin
        line_base_d = line_base_q;
      end
    end else begin
      line_base_d = line_base_q;
    end
  end

`ifdef VGA_WR_BUFFER_EN
  logic [g_Addr_Width-1:0] fifo_addr_q [4];
  logic [g_Data_Width-1:0] fifo_data_q [4];
  logic [1:0]              wr_ptr_q, rd_ptr_q;
  logic [2:0]              count_q, count_d;
  logic                    accept_s, push_s, pop_s;

  // Out-of-range requests are acked with an error but never occupy a FIFO slot.
  assign accept_s = (state_q == W_IDLE) && bus.i_Wr_Req && (count_q != 3'd4);
  assign push_s   = accept_s && !wr_oor_s;
  assign pop_s    = !slot_s && (count_q != 3'd0);
  assign count_d  = count_q + {2'b00, push_s} - {2'b00, pop_s};

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < 4; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_addr_q[wr_ptr_q] <= bus.i_Wr_Addr;
        fifo_data_q[wr_ptr_q] <= bus.i_Wr_Data;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = rd_addr_s;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    ack_d       = accept_s;
    err_d       = accept_s && wr_oor_s;
    case (state_q)
      W_IDLE:  state_d = accept_s ? W_ACK : W_IDLE;
      W_ACK:   state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
    if (pop_s) begin
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_we_d    = 1'b1;
      mem_wdata_d = fifo_data_q[rd_ptr_q];
    end else begin
      mem_addr_d  = rd_addr_s;
    end
  end
`else
  // Writer is granted only outside display slots; W_ACK blocks re-acceptance of a held request.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = rd_addr_s;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (bus.i_Wr_Req && !slot_s) begin
          ack_d   = 1'b1;
          err_d   = wr_oor_s;
          state_d = W_ACK;
          if (!wr_oor_s) begin
            mem_addr_d  = bus.i_Wr_Addr;
            mem_we_d    = 1'b1;
            mem_wdata_d = bus.i_Wr_Data;
          end else begin
            mem_addr_d  = rd_addr_s;
          end
        end else begin
          state_d = W_IDLE;
        end
      end
      W_ACK:   state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end
`endif

  always_comb begin
    pixel_d = valid2_q ? rdata_q : '0;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= W_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Display pipeline: address at n+1, read data sampled at n+2, pixel presented at n+3.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      line_base_q <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      valid1_q    <= 1'b0;
      valid2_q    <= 1'b0;
      rdata_q     <= '0;
      pixel_q     <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      line_base_q <= line_base_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      valid1_q    <= slot_s;
      valid2_q    <= valid1_q;
      rdata_q     <= bus.i_Mem_RData;
      pixel_q     <= pixel_d;
      pix_valid_q <= valid2_q;
    end
  end

  assign bus.o_Mem_Addr    = mem_addr_q;
  assign bus.o_Mem_WE      = mem_we_q;
  assign bus.o_Mem_WData   = mem_wdata_q;
  assign bus.o_Wr_Ack      = ack_q;
  assign bus.o_Wr_Err      = err_q;
  assign bus.o_Pixel       = pixel_q;
  assign bus.o_Pixel_Valid = pix_valid_q;

endmodule
